// File: rtl/mdu_iter_if.sv
// Bus between the CPU control path and the iterative multiply/divide unit.
//
// Handshake: the master raises start for a cycle with op/a/b valid; the unit
// accepts it only while busy is low (busy acts as the inverted ready). Once
// accepted, busy stays high until the result is written, and done pulses
// for exactly one cycle when hi/lo carry the new result. mthi/mtlo are
// single-cycle writes honoured only while idle and without start.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       fsm_state;   // debug view of the unit's FSM state

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo, fsm_state
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo, fsm_state
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per clock over WIDTH clocks, then a sign fix-up cycle that
// writes HI/LO. Signed operations run on magnitudes; signs are reapplied in FIX.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    mdu_iter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;     // negate product (mult) or quotient (div)
    logic             neg_r;     // negate remainder (signed div, negative dividend)
    logic [WIDTH-1:0] d;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0] rem;       // product upper half / partial remainder
    logic [WIDTH-1:0] quo;       // multiplier being consumed / quotient bits
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    logic               sgn_op;
    logic               div_zero;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign sgn_op   = ~bus.op[0];
    assign div_zero = bus.op[1] && (bus.b == '0);
    assign a_abs    = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs    = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign mul_sum   = {1'b0, rem} + {1'b0, (quo[0] ? d : '0)};
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, d};

    assign prod_fix = neg_q ? -{rem, quo} : {rem, quo};
    assign q_fix    = neg_q ? -quo : quo;
    assign r_fix    = neg_r ? -rem : rem;

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;
    assign bus.fsm_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: accept start when idle, WIDTH iterations, one fix-up cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result write and HI/LO moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            d      <= '0;
            rem    <= '0;
            quo    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        rem    <= '0;
                        cnt    <= '0;
                        if (div_zero) begin
                            // Raw bits with a zero divisor make the restoring
                            // loop yield quotient all-ones and remainder = a.
                            quo   <= bus.a;
                            d     <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            quo   <= a_abs;
                            d     <= b_abs;
                            neg_q <= sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_r <= sgn_op && bus.op[1] && bus.a[WIDTH-1];
                        end
                    end else begin
                        if (bus.mthi) hi_r <= bus.a;
                        if (bus.mtlo) lo_r <= bus.a;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (!div_diff[WIDTH+1]) begin
                            rem <= div_diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= div_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {rem, quo} <= {mul_sum, quo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi_r <= r_fix;
                        lo_r <= q_fix;
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
